fetch_stage: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register.
- Owns the PC and issues one instruction-memory request at a time over a valid/ready handshake.
- Buffers the returned word and presents instr/opcode/funct/PC+4 to the decode stage. The decode-stage control unit consumes opcode and funct.
- Handles hazard stalls and branch/jump/jr redirects (flush) from downstream.

---
 rtl/fetch_stage_pkg.sv | 18 +
 rtl/fetch_skid_buffer.sv | 42 ++++
 rtl/fetch_stage.sv | 138 +++++++++++++
 tb/tb_fetch_stage.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared constants, field positions and fetch state encoding
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// rtl/fetch_skid_buffer.sv - one-entry instr+pc4 holding buffer used while decode is stalled
module fetch_skid_buffer #(
  parameter int PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_load,
  input  logic                i_drain,
  input  logic                i_flush,
  input  logic [31:0]         i_instr,
  input  logic [PC_WIDTH-1:0] i_pc4,
  output logic                o_valid,
  output logic [31:0]         o_instr,
  output logic [PC_WIDTH-1:0] o_pc4
);

  logic                r_valid;
  logic [31:0]         r_instr;
  logic [PC_WIDTH-1:0] r_pc4;

  // Flush wins over load so a redirect never leaves a stale word behind.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc4   <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc4   <= i_pc4;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc4   = r_pc4;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC, single-outstanding imem fetch FSM and IF/ID register
// Optional FETCH_ALIGN_CHECK_EN: adds sticky addr_err and word-aligns redirect targets.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                imem_req_valid,
  output logic [PC_WIDTH-1:0] imem_req_addr,
  input  logic                imem_req_ready,
  input  logic                imem_rsp_valid,
  input  logic [31:0]         imem_rsp_data,
  output logic                ifid_valid,
  output logic [31:0]         ifid_instr,
  output logic [5:0]          ifid_opcode,
  output logic [5:0]          ifid_funct,
  output logic [PC_WIDTH-1:0] ifid_pc4
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic                addr_err
`endif
);

  fetch_state_t        r_state;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] r_tag;
  logic                r_ifid_valid;
  logic [31:0]         r_ifid_instr;
  logic [PC_WIDTH-1:0] r_ifid_pc4;

  logic                w_skid_valid;
  logic [31:0]         w_skid_instr;
  logic [PC_WIDTH-1:0] w_skid_pc4;
  logic                w_req_valid;
  logic                w_accept;
  logic                w_rsp_take;
  logic [PC_WIDTH-1:0] w_tag_pc4;
  logic [PC_WIDTH-1:0] w_redirect_target;

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_addr_err;
  assign w_redirect_target = {redirect_pc[PC_WIDTH-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (!rst)
      r_addr_err <= 1'b0;
    else if (redirect_valid && (redirect_pc[1:0] != 2'b00))
      r_addr_err <= 1'b1;
  end

  assign addr_err = r_addr_err;
`else
  assign w_redirect_target = redirect_pc;
`endif

  // A full skid means decode still owes us a slot, so hold off new fetches.
  assign w_req_valid = rst && (r_state == S_REQ) && !w_skid_valid;
  assign w_accept    = w_req_valid && imem_req_ready;
  assign w_rsp_take  = (r_state == S_WAIT) && imem_rsp_valid;
  assign w_tag_pc4   = r_tag + PC_WIDTH'(4);

  fetch_skid_buffer #(.PC_WIDTH(PC_WIDTH)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (!redirect_valid && stall && w_rsp_take),
    .i_drain (!redirect_valid && !stall && w_skid_valid),
    .i_flush (redirect_valid),
    .i_instr (imem_rsp_data),
    .i_pc4   (w_tag_pc4),
    .o_valid (w_skid_valid),
    .o_instr (w_skid_instr),
    .o_pc4   (w_skid_pc4)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_REQ;
      r_pc         <= RESET_PC;
      r_tag        <= '0;
      r_ifid_valid <= 1'b0;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_pc4   <= '0;
    end else if (redirect_valid) begin
      r_pc         <= w_redirect_target;
      r_ifid_valid <= 1'b0;
      r_ifid_instr <= NOP_INSTR;
      // Anything in flight at the redirect belongs to the wrong path.
      case (r_state)
        S_REQ:   r_state <= w_accept ? S_DROP : S_REQ;
        S_WAIT:  r_state <= imem_rsp_valid ? S_REQ : S_DROP;
        S_DROP:  r_state <= imem_rsp_valid ? S_REQ : S_DROP;
        default: r_state <= S_REQ;
      endcase
    end else begin
      case (r_state)
        S_REQ: begin
          if (w_accept) begin
            r_tag   <= r_pc;
            r_pc    <= r_pc + PC_WIDTH'(4);
            r_state <= S_WAIT;
          end
        end
        S_WAIT:  if (imem_rsp_valid) r_state <= S_REQ;
        S_DROP:  if (imem_rsp_valid) r_state <= S_REQ;
        default: r_state <= S_REQ;
      endcase
      if (!stall) begin
        if (w_skid_valid) begin
          r_ifid_valid <= 1'b1;
          r_ifid_instr <= w_skid_instr;
          r_ifid_pc4   <= w_skid_pc4;
        end else if (w_rsp_take) begin
          r_ifid_valid <= 1'b1;
          r_ifid_instr <= imem_rsp_data;
          r_ifid_pc4   <= w_tag_pc4;
        end else begin
          r_ifid_valid <= 1'b0;
          r_ifid_instr <= NOP_INSTR;
        end
      end
    end
  end

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_pc;
  assign ifid_valid     = r_ifid_valid;
  assign ifid_instr     = r_ifid_instr;
  assign ifid_opcode    = r_ifid_instr[OPCODE_MSB:OPCODE_LSB];
  assign ifid_funct     = r_ifid_instr[FUNCT_MSB:FUNCT_LSB];
  assign ifid_pc4       = r_ifid_pc4;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed plus randomized checks of fetch_stage against a transaction-level model
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [5:0]  ifid_opcode;
  logic [5:0]  ifid_funct;
  logic [31:0] ifid_pc4;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        addr_err;
`endif

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .ifid_valid     (ifid_valid),
    .ifid_instr     (ifid_instr),
    .ifid_opcode    (ifid_opcode),
    .ifid_funct     (ifid_funct),
    .ifid_pc4       (ifid_pc4)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .addr_err       (addr_err)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } word_t;

  // Transaction-level model: an in-flight fetch is either wanted (busy) or doomed (drop).
  logic        m_known = 1'b0;
  logic [31:0] m_pc, m_tag;
  logic        m_busy, m_drop, m_err;
  word_t       m_skid[$];
  logic        m_ifid_valid;
  logic [31:0] m_ifid_instr, m_ifid_pc4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic logic model_req();
    return rst && !m_busy && !m_drop && (m_skid.size() == 0);
  endfunction

  task automatic model_step();
    logic        acc, got;
    logic [31:0] tgt;
    word_t       w;
    if (!rst) begin
      m_pc = 32'h0; m_tag = 32'h0; m_busy = 1'b0; m_drop = 1'b0; m_err = 1'b0;
      m_skid.delete();
      m_ifid_valid = 1'b0; m_ifid_instr = 32'h0; m_ifid_pc4 = 32'h0;
      m_known = 1'b1;
      return;
    end
    acc = model_req() && imem_req_ready;
    got = m_busy && imem_rsp_valid;
    tgt = redirect_pc;
`ifdef FETCH_ALIGN_CHECK_EN
    tgt[1:0] = 2'b00;
`endif
    if (redirect_valid) begin
`ifdef FETCH_ALIGN_CHECK_EN
      if (redirect_pc[1:0] != 2'b00) m_err = 1'b1;
`endif
      m_drop = ((m_busy || m_drop) && !imem_rsp_valid) || acc;
      m_busy = 1'b0;
      m_pc = tgt;
      m_skid.delete();
      m_ifid_valid = 1'b0;
      m_ifid_instr = 32'h0;
      return;
    end
    if (m_drop && imem_rsp_valid) m_drop = 1'b0;
    if (got) m_busy = 1'b0;
    w.instr = imem_rsp_data;
    w.pc4 = m_tag + 32'd4;
    if (stall) begin
      if (got) m_skid.push_back(w);
    end else if (m_skid.size() != 0) begin
      w = m_skid.pop_front();
      m_ifid_valid = 1'b1; m_ifid_instr = w.instr; m_ifid_pc4 = w.pc4;
    end else if (got) begin
      m_ifid_valid = 1'b1; m_ifid_instr = w.instr; m_ifid_pc4 = w.pc4;
    end else begin
      m_ifid_valid = 1'b0; m_ifid_instr = 32'h0;
    end
    if (acc) begin
      m_tag = m_pc;
      m_pc = m_pc + 32'd4;
      m_busy = 1'b1;
    end
  endtask

  // Compare mid-cycle, advance the model with this cycle's inputs, then step past the edge.
  task automatic tick();
    logic exp_rv;
    @(negedge clk);
    if (m_known) begin
      exp_rv = model_req();
      chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
      if (exp_rv) chk("req_addr", imem_req_addr, m_pc);
      chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_ifid_valid});
      chk("ifid_instr", ifid_instr, m_ifid_instr);
      chk("ifid_opcode", {26'b0, ifid_opcode}, {26'b0, m_ifid_instr[31:26]});
      chk("ifid_funct", {26'b0, ifid_funct}, {26'b0, m_ifid_instr[5:0]});
      if (m_ifid_valid) chk("ifid_pc4", ifid_pc4, m_ifid_pc4);
`ifdef FETCH_ALIGN_CHECK_EN
      chk("addr_err", {31'b0, addr_err}, {31'b0, m_err});
`endif
    end
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    tick(); tick();
    chk("rst_ifid_valid", {31'b0, ifid_valid}, 32'h0);
    chk("rst_ifid_instr", ifid_instr, 32'h0);
    chk("rst_ifid_pc4", ifid_pc4, 32'h0);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    rst = 1'b1; #1;
    chk("first_req_valid", {31'b0, imem_req_valid}, 32'h1);
    chk("first_req_addr", imem_req_addr, 32'h0);

    // First fetch and 1-cycle response latency
    imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h012A_4020; tick(); imem_rsp_valid = 1'b0;
    chk("first_valid", {31'b0, ifid_valid}, 32'h1);
    chk("first_opcode", {26'b0, ifid_opcode}, 32'h0);
    chk("first_funct", {26'b0, ifid_funct}, 32'h20);
    chk("first_pc4", ifid_pc4, 32'h4);

    // Stall across a response: word parks in the skid, no new request
    stall = 1'b1; imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h8C22_0004; tick(); imem_rsp_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("stall_hold_instr", ifid_instr, 32'h012A_4020);
      chk("stall_hold_valid", {31'b0, ifid_valid}, 32'h1);
      chk("stall_no_req", {31'b0, imem_req_valid}, 32'h0);
      tick();
    end
    chk("stall_hold_end", ifid_instr, 32'h012A_4020);
    stall = 1'b0; tick();
    chk("skid_drain_instr", ifid_instr, 32'h8C22_0004);
    chk("skid_drain_pc4", ifid_pc4, 32'h8);
    chk("post_skid_req", {31'b0, imem_req_valid}, 32'h1);
    chk("post_skid_addr", imem_req_addr, 32'h8);

    // Redirect while waiting: outstanding response dropped
    imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h100; tick(); redirect_valid = 1'b0;
    chk("redir_flush", {31'b0, ifid_valid}, 32'h0);
    chk("redir_drop_noreq", {31'b0, imem_req_valid}, 32'h0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF; tick(); imem_rsp_valid = 1'b0;
    chk("dropped_rsp", {31'b0, ifid_valid}, 32'h0);
    chk("redir_addr", imem_req_addr, 32'h100);

    // Back-pressure on the request channel
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_valid", {31'b0, imem_req_valid}, 32'h1);
      chk("bp_addr", imem_req_addr, 32'h100);
    end
    imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_000C; tick(); imem_rsp_valid = 1'b0;
    chk("bp_pc4", ifid_pc4, 32'h104);

    // PC wrap
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; tick(); redirect_valid = 1'b0;
    chk("wrap_addr_pre", imem_req_addr, 32'hFFFF_FFFC);
    imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h2108_0001; tick(); imem_rsp_valid = 1'b0;
    chk("wrap_pc4", ifid_pc4, 32'h0);
    chk("wrap_next_addr", imem_req_addr, 32'h0);

`ifdef FETCH_ALIGN_CHECK_EN
    redirect_valid = 1'b1; redirect_pc = 32'h102; tick(); redirect_valid = 1'b0;
    chk("align_err", {31'b0, addr_err}, 32'h1);
    chk("align_addr", imem_req_addr, 32'h100);
    tick();
    chk("align_sticky", {31'b0, addr_err}, 32'h1);
`endif

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst            = ($urandom_range(0, 199) != 0);
      stall          = ($urandom_range(0, 9) < 3);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : $urandom;
      imem_req_ready = ($urandom_range(0, 1) == 1);
      imem_rsp_valid = (m_busy || m_drop) && ($urandom_range(0, 2) == 0);
      imem_rsp_data  = $urandom;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
